// File: rtl/mem_lsu.sv
// Load/store initiator for the MEM stage: maps byte/half/word requests onto a word-wide
// data memory, using read-modify-write for sub-word stores and extending load data.
module mem_lsu #(
    parameter int MEM_DEPTH   = 256,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | reading the target word (loads, sub-word store merge)
    // WR    | writing the (merged) word
    // RESP  | one-cycle completion pulse, possibly with error
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, err_q;
    logic        req_fire, req_err, range_bad;
    logic [31:0] merged, load_ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign req_ready = (state_q == IDLE);
    assign req_fire  = req_valid && req_ready;

    always_comb begin
        range_bad = 1'b0;
        if (CHECK_RANGE)
            range_bad = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
        req_err = (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
               || range_bad;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_we || req_size != 2'd2)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
            end
            if (state_q == RD)
                rdata_q <= mem_rdata;
        end
    end

    // Little-endian lane k = bits [8k+7:8k]
    always_comb begin
        merged = rdata_q;
        case (size_q)
            2'd0:    merged[8*addr_q[1:0] +: 8]  = wdata_q[7:0];
            2'd1:    merged[16*addr_q[1]  +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        lane_b = rdata_q[8*addr_q[1:0] +: 8];
        lane_h = rdata_q[16*addr_q[1] +: 16];
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'd1:    load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = rdata_q;
        endcase
    end

    // Access strobes drop immediately on reset so an in-flight write never lands
    assign mem_read   = rst_n && (state_q == RD);
    assign mem_write  = rst_n && (state_q == WR);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = (state_q == WR) ? merged : 32'h0;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP && !err_q && !we_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: word-wide memory model plus hand-computed expectations
// for stores, loads, error responses and reset during a write.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_lsu #(.MEM_DEPTH(256), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [256];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

    int          n_rd = 0, n_wr = 0, n_resp = 0, n_both = 0;
    logic [31:0] last_wdata = 32'h0, last_waddr = 32'h0;
    always @(negedge clk) begin
        if (mem_read) n_rd++;
        if (mem_write) begin
            n_wr++;
            last_wdata = mem_wdata;
            last_waddr = mem_addr;
        end
        if (resp_valid) n_resp++;
        if (mem_read && mem_write) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int rd, output int wr);
        int rd0, wr0;
        @(negedge clk);
        rd0 = n_rd;
        wr0 = n_wr;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'h0; err = 1'b0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        rd = n_rd - rd0;
        wr = n_wr - wr0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        string       tag;
    } err_vec_t;

    initial begin
        int          lat, rd, wr, wr0, resp0;
        logic [31:0] rdata;
        logic        err;
        err_vec_t    errs[5];

        errs[0] = '{1'b0, 2'd2, 32'h13,  "err_word_13"};
        errs[1] = '{1'b0, 2'd1, 32'h21,  "err_half_21"};
        errs[2] = '{1'b0, 2'd3, 32'h0,   "err_size3"};
        errs[3] = '{1'b0, 2'd2, 32'h400, "err_range_400"};
        errs[4] = '{1'b1, 2'd2, 32'h13,  "err_store_13"};

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdata, err, rd, wr);
        chk("sw_lat", lat, 2);
        chk("sw_writes", wr, 1);
        chk("sw_reads", rd, 0);
        chk("sw_addr", last_waddr, 32'h10);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        chk("sw_err", {31'h0, err}, 32'h0);

        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rdata, err, rd, wr);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_err", {31'h0, err}, 32'h0);
        chk("lw_reads", rd, 1);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, lat, rdata, err, rd, wr);
        xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, lat, rdata, err, rd, wr);
        chk("sb_lat", lat, 3);
        chk("sb_reads", rd, 1);
        chk("sb_writes", wr, 1);
        chk("sb_wdata", last_wdata, 32'h1122AA44);
        chk("sb_rdata", rdata, 32'h0);

        xact(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, lat, rdata, err, rd, wr);
        chk("lb_signed", rdata, 32'hFFFFFFAA);
        xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, rdata, err, rd, wr);
        chk("lb_unsigned", rdata, 32'h000000AA);
        xact(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, rdata, err, rd, wr);
        chk("lb_lane0", rdata, 32'h00000044);

        xact(1'b1, 2'd2, 1'b0, 32'h14, 32'h11223344, lat, rdata, err, rd, wr);
        xact(1'b1, 2'd1, 1'b0, 32'h16, 32'h00008001, lat, rdata, err, rd, wr);
        chk("sh_lat", lat, 3);
        chk("sh_wdata", last_wdata, 32'h80013344);
        xact(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, lat, rdata, err, rd, wr);
        chk("lh_signed", rdata, 32'hFFFF8001);
        xact(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, lat, rdata, err, rd, wr);
        chk("lh_unsigned", rdata, 32'h00008001);
        xact(1'b0, 2'd1, 1'b0, 32'h14, 32'h0, lat, rdata, err, rd, wr);
        chk("lh_low", rdata, 32'h00003344);

        foreach (errs[i]) begin
            xact(errs[i].we, errs[i].size, 1'b0, errs[i].addr, 32'hCAFEF00D, lat, rdata, err, rd, wr);
            chk({errs[i].tag, "_err"}, {31'h0, err}, 32'h1);
            chk({errs[i].tag, "_rdata"}, rdata, 32'h0);
            chk({errs[i].tag, "_lat"}, lat, 1);
            chk({errs[i].tag, "_access"}, rd + wr, 0);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rdata, err, rd, wr);
        chk("after_err_word10", rdata, 32'h1122AA44);

        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, lat, rdata, err, rd, wr);
        @(negedge clk);
        wr0 = n_wr;
        resp0 = n_resp;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("mid_rd", {31'h0, mem_read}, 32'h1);
        @(posedge clk);
        #1;
        chk("mid_wr_pre", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_wr_gated", {31'h0, mem_write}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("mid_no_write", n_wr - wr0, 0);
        chk("mid_no_resp", n_resp - resp0, 0);
        chk("mid_idle", {31'h0, req_ready}, 32'h1);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rdata, err, rd, wr);
        chk("mid_mem_kept", rdata, 32'h11223344);

        chk("rd_wr_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
